// File: rtl/rotor_stepper_pkg.sv
// Shared constants for the rotor stepping stage: alphabet size, default notches,
// FSM state encodings and the wrap-increment helper.
package rotor_stepper_pkg;

    localparam int              LETTER_W        = 8;
    localparam logic [7:0]      ALPHA_SIZE_DEF  = 8'd26;
    localparam logic [7:0]      NOTCH_RIGHT_DEF = 8'd21;
    localparam logic [7:0]      NOTCH_MID_DEF   = 8'd4;

    localparam logic [1:0]      ST_IDLE    = 2'd0;
    localparam logic [1:0]      ST_STEP    = 2'd1;
    localparam logic [1:0]      ST_PRESENT = 2'd2;

    typedef struct packed {
        logic [LETTER_W-1:0] left;
        logic [LETTER_W-1:0] mid;
        logic [LETTER_W-1:0] right;
    } rotor_pos_t;

    // +1 with wrap at modulus m; anything at or above m-1 lands on 0.
    function automatic logic [7:0] mod_inc(input logic [7:0] v, input logic [7:0] m);
        return (v >= m - 8'd1) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/rotor_stepper_if.sv
// Keypress/load inputs and character/rotor outputs between the keyboard stage,
// the rotor stepper and the downstream letter shifters.
interface rotor_stepper_if;
    import rotor_stepper_pkg::*;

    logic                load;
    logic [LETTER_W-1:0] load_right;
    logic [LETTER_W-1:0] load_mid;
    logic [LETTER_W-1:0] load_left;
    logic                key_valid;
    logic [LETTER_W-1:0] key_char;
    logic                busy;
    logic                out_valid;
    logic [LETTER_W-1:0] out_char;
    logic [LETTER_W-1:0] rotor_right;
    logic [LETTER_W-1:0] rotor_mid;
    logic [LETTER_W-1:0] rotor_left;

    modport master (
        output load, load_right, load_mid, load_left, key_valid, key_char,
        input  busy, out_valid, out_char, rotor_right, rotor_mid, rotor_left
    );

    modport slave (
        input  load, load_right, load_mid, load_left, key_valid, key_char,
        output busy, out_valid, out_char, rotor_right, rotor_mid, rotor_left
    );

endinterface

// File: rtl/rotor_stepper_counter.sv
// One rotor position: mod-ALPHA counter with sanitised parallel load and a
// notch compare on the current (pre-step) position.
module rotor_counter
    import rotor_stepper_pkg::*;
#(
    parameter logic [7:0] NOTCH = 8'd0,
    parameter logic [7:0] ALPHA = ALPHA_SIZE_DEF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_step,
    input  logic       i_load,
    input  logic [7:0] i_load_value,
    output logic [7:0] o_value,
    output logic       o_at_notch
);

    logic [7:0] r_value;
    logic [7:0] w_load_clean;

    assign w_load_clean = (i_load_value >= ALPHA) ? 8'd0 : i_load_value;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_value <= 8'd0;
        end else if (i_load) begin
            r_value <= w_load_clean;
        end else if (i_step) begin
            r_value <= mod_inc(r_value, ALPHA);
        end
    end

    assign o_value    = r_value;
    assign o_at_notch = (r_value == NOTCH);

endmodule

// File: rtl/rotor_stepper.sv
// Rotor position owner: captures a keypress, steps the rotors odometer-style
// (with middle-rotor double-step) and strobes the result downstream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting; load latches positions, key_valid captures a char
// ST_STEP    | rotors advance on the edge leaving this state
// ST_PRESENT | out_valid high; outputs stable for the letter shifters
module rotor_stepper
    import rotor_stepper_pkg::*;
#(
    parameter logic [7:0] NOTCH_RIGHT = NOTCH_RIGHT_DEF,
    parameter logic [7:0] NOTCH_MID   = NOTCH_MID_DEF,
    parameter logic [7:0] ALPHA_SIZE  = ALPHA_SIZE_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    rotor_stepper_if.slave bus
);

    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_out_valid;
    logic [LETTER_W-1:0] r_out_char;

    logic       w_load;
    logic       w_step;
    logic       w_notch_r;
    logic       w_notch_m;
    logic       w_unused_notch_l;
    rotor_pos_t w_pos;

    assign w_load = (r_state == ST_IDLE) && bus.load;
    assign w_step = (r_state == ST_STEP);

    // Notch flags reflect pre-step positions, so all three decisions use R, M, L.
    rotor_counter #(.NOTCH(NOTCH_RIGHT), .ALPHA(ALPHA_SIZE)) u_right (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_step       (w_step),
        .i_load       (w_load),
        .i_load_value (bus.load_right),
        .o_value      (w_pos.right),
        .o_at_notch   (w_notch_r)
    );

    rotor_counter #(.NOTCH(NOTCH_MID), .ALPHA(ALPHA_SIZE)) u_mid (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_step       (w_step && (w_notch_r || w_notch_m)),
        .i_load       (w_load),
        .i_load_value (bus.load_mid),
        .o_value      (w_pos.mid),
        .o_at_notch   (w_notch_m)
    );

    rotor_counter #(.NOTCH(8'd0), .ALPHA(ALPHA_SIZE)) u_left (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_step       (w_step && w_notch_m),
        .i_load       (w_load),
        .i_load_value (bus.load_left),
        .o_value      (w_pos.left),
        .o_at_notch   (w_unused_notch_l)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (!bus.load && bus.key_valid) begin
                        r_out_char <= bus.key_char;
                        r_busy     <= 1'b1;
                        r_state    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_out_valid <= 1'b1;
                    r_state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_char    = r_out_char;
    assign bus.rotor_right = w_pos.right;
    assign bus.rotor_mid   = w_pos.mid;
    assign bus.rotor_left  = w_pos.left;

endmodule

// File: tb/tb_rotor_stepper.sv
// Bench for rotor_stepper: directed scenarios plus a randomized run, all checked
// against an arithmetic Enigma stepping model.
module tb_rotor_stepper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rotor_stepper_if ifc0();
    rotor_stepper_if ifc1();

    rotor_stepper u_dut0 (.i_clock(clk), .i_reset(rst), .bus(ifc0));
    rotor_stepper #(.NOTCH_RIGHT(8'd25), .NOTCH_MID(8'd25)) u_dut1 (.i_clock(clk), .i_reset(rst), .bus(ifc1));

    int tests = 0;
    int fails = 0;
    int ov0 = 0;
    int ov1 = 0;

    always @(negedge clk) begin
        if (ifc0.out_valid === 1'b1) ov0++;
        if (ifc1.out_valid === 1'b1) ov1++;
    end

    // Reference model: positions as plain integers, stepping by the Enigma rules.
    int mr, mm, ml;

    task automatic model_step(input int notch_r, input int notch_m);
        int r, m, l;
        r = mr; m = mm; l = ml;
        mr = (r + 1) % 26;
        if (r == notch_r || m == notch_m) mm = (m + 1) % 26;
        if (m == notch_m) ml = (l + 1) % 26;
    endtask

    task automatic model_load(input int r, input int m, input int l);
        mr = (r < 26) ? r : 0;
        mm = (m < 26) ? m : 0;
        ml = (l < 26) ? l : 0;
    endtask

    function automatic logic [23:0] model_pos();
        return {8'(ml), 8'(mm), 8'(mr)};
    endfunction

    function automatic logic [23:0] dut0_pos();
        return {ifc0.rotor_left, ifc0.rotor_mid, ifc0.rotor_right};
    endfunction

    task automatic do_load(input int r, input int m, input int l);
        @(posedge clk); #1;
        ifc0.load = 1'b1;
        ifc0.load_right = 8'(r); ifc0.load_mid = 8'(m); ifc0.load_left = 8'(l);
        @(posedge clk); #1;
        ifc0.load = 1'b0;
        ifc0.load_right = 8'($urandom); ifc0.load_mid = 8'($urandom); ifc0.load_left = 8'($urandom);
        model_load(r, m, l);
    endtask

    task automatic do_key(input logic [7:0] c, output int lat, output logic [7:0] oc,
                          output logic b_step, output logic b_pres);
        @(posedge clk); #1;
        ifc0.key_valid = 1'b1;
        ifc0.key_char  = c;
        @(posedge clk); #1;
        ifc0.key_valid = 1'b0;
        ifc0.key_char  = 8'($urandom);
        b_step = ifc0.busy;
        lat = 1;
        while (ifc0.out_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        b_pres = ifc0.busy;
        oc = ifc0.out_char;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++;
        if ({ifc0.busy, ifc0.out_valid, ifc0.out_char, dut0_pos()} !== 34'd0) begin
            fails++;
            $display("FAIL reset_state dut0 got busy=%b ov=%b char=%0d pos=%h want all zero",
                     ifc0.busy, ifc0.out_valid, ifc0.out_char, dut0_pos());
        end
        tests++;
        if ({ifc1.busy, ifc1.out_valid, ifc1.out_char, ifc1.rotor_left, ifc1.rotor_mid, ifc1.rotor_right} !== 34'd0) begin
            fails++;
            $display("FAIL reset_state dut1 not all zero");
        end
        model_load(0, 0, 0);
    endtask

    task automatic test_basic_key();
        int lat; logic [7:0] oc; logic bs, bp; int ov_before;
        ov_before = ov0;
        do_key(8'd7, lat, oc, bs, bp);
        model_step(21, 4);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL basic_latency got %0d want 2", lat); end
        tests++;
        if (oc !== 8'd7) begin fails++; $display("FAIL basic_out_char got %0d want 7", oc); end
        tests++;
        if ({bs, bp} !== 2'b11) begin fails++; $display("FAIL basic_busy got %b%b want 11", bs, bp); end
        tests++;
        if (dut0_pos() !== model_pos()) begin
            fails++; $display("FAIL basic_pos got %h want %h", dut0_pos(), model_pos());
        end
        tests++;
        if (ov0 - ov_before !== 1) begin fails++; $display("FAIL basic_strobe_count got %0d want 1", ov0 - ov_before); end
        tests++;
        if (ifc0.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_release got %b want 0", ifc0.busy); end
    endtask

    task automatic test_double_step();
        int lat; logic [7:0] oc; logic bs, bp;
        do_load(20, 3, 0);
        tests++;
        if (dut0_pos() !== 24'h000314) begin fails++; $display("FAIL dstep_load got %h want 000314", dut0_pos()); end
        for (int k = 0; k < 3; k++) begin
            do_key(8'(65 + k), lat, oc, bs, bp);
            model_step(21, 4);
            tests++;
            if (dut0_pos() !== model_pos()) begin
                fails++; $display("FAIL dstep_key%0d got %h want %h", k, dut0_pos(), model_pos());
            end
        end
        tests++;
        if (dut0_pos() !== 24'h010517) begin fails++; $display("FAIL dstep_final got %h want 010517", dut0_pos()); end
    endtask

    task automatic test_wrap();
        int ov_before; int waited;
        ov_before = ov1;
        @(posedge clk); #1;
        ifc1.load = 1'b1; ifc1.load_right = 8'd25; ifc1.load_mid = 8'd25; ifc1.load_left = 8'd25;
        @(posedge clk); #1;
        ifc1.load = 1'b0; ifc1.key_valid = 1'b1; ifc1.key_char = 8'd90;
        @(posedge clk); #1;
        ifc1.key_valid = 1'b0;
        waited = 0;
        while (ifc1.out_valid !== 1'b1 && waited < 8) begin @(posedge clk); #1; waited++; end
        tests++;
        if (waited !== 1) begin fails++; $display("FAIL wrap_latency got %0d want 1 extra cycle", waited); end
        tests++;
        if ({ifc1.rotor_left, ifc1.rotor_mid, ifc1.rotor_right} !== 24'h000000) begin
            fails++; $display("FAIL wrap_pos got %h want 000000", {ifc1.rotor_left, ifc1.rotor_mid, ifc1.rotor_right});
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ov1 - ov_before !== 1) begin fails++; $display("FAIL wrap_strobe_count got %0d want 1", ov1 - ov_before); end
    endtask

    task automatic test_busy_ignore();
        int ov_before;
        do_load(5, 10, 15);
        ov_before = ov0;
        @(posedge clk); #1;
        ifc0.key_valid = 1'b1; ifc0.key_char = 8'h41;
        @(posedge clk); #1;
        ifc0.key_char = 8'h42;
        @(posedge clk); #1;
        ifc0.key_valid = 1'b0;
        ifc0.load = 1'b1; ifc0.load_right = 8'd1; ifc0.load_mid = 8'd2; ifc0.load_left = 8'd3;
        tests++;
        if (ifc0.out_valid !== 1'b1) begin fails++; $display("FAIL busy_present_strobe got %b want 1", ifc0.out_valid); end
        @(posedge clk); #1;
        ifc0.load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_step(21, 4);
        tests++;
        if (ov0 - ov_before !== 1) begin fails++; $display("FAIL busy_strobe_count got %0d want 1", ov0 - ov_before); end
        tests++;
        if (ifc0.out_char !== 8'h41) begin fails++; $display("FAIL busy_out_char got %h want 41", ifc0.out_char); end
        tests++;
        if (dut0_pos() !== model_pos()) begin
            fails++; $display("FAIL busy_pos got %h want %h", dut0_pos(), model_pos());
        end
    endtask

    task automatic test_load_sanitize();
        do_load(30, 3, 2);
        tests++;
        if (dut0_pos() !== model_pos()) begin fails++; $display("FAIL sanitize_right got %h want %h", dut0_pos(), model_pos()); end
        do_load(7, 26, 255);
        tests++;
        if (dut0_pos() !== model_pos()) begin fails++; $display("FAIL sanitize_mid_left got %h want %h", dut0_pos(), model_pos()); end
    endtask

    task automatic test_load_priority();
        int ov_before;
        ov_before = ov0;
        @(posedge clk); #1;
        ifc0.load = 1'b1; ifc0.key_valid = 1'b1; ifc0.key_char = 8'd99;
        ifc0.load_right = 8'd4; ifc0.load_mid = 8'd5; ifc0.load_left = 8'd6;
        @(posedge clk); #1;
        ifc0.load = 1'b0; ifc0.key_valid = 1'b0;
        model_load(4, 5, 6);
        tests++;
        if (ifc0.busy !== 1'b0) begin fails++; $display("FAIL prio_busy got %b want 0", ifc0.busy); end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (ov0 - ov_before !== 0) begin fails++; $display("FAIL prio_strobe_count got %0d want 0", ov0 - ov_before); end
        tests++;
        if (dut0_pos() !== model_pos()) begin fails++; $display("FAIL prio_pos got %h want %h", dut0_pos(), model_pos()); end
    endtask

    task automatic test_reset_mid();
        int ov_before; int lat; logic [7:0] oc; logic bs, bp;
        do_load(10, 11, 12);
        ov_before = ov0;
        @(posedge clk); #1;
        ifc0.key_valid = 1'b1; ifc0.key_char = 8'd55;
        @(posedge clk); #1;
        ifc0.key_valid = 1'b0;
        tests++;
        if (ifc0.busy !== 1'b1) begin fails++; $display("FAIL rstmid_in_step busy got %b want 1", ifc0.busy); end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({ifc0.busy, ifc0.out_valid, ifc0.out_char, dut0_pos()} !== 34'd0) begin
            fails++; $display("FAIL rstmid_async got busy=%b ov=%b char=%0d pos=%h want all zero",
                              ifc0.busy, ifc0.out_valid, ifc0.out_char, dut0_pos());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ov0 - ov_before !== 0) begin fails++; $display("FAIL rstmid_no_strobe got %0d want 0", ov0 - ov_before); end
        model_load(0, 0, 0);
        do_key(8'd3, lat, oc, bs, bp);
        model_step(21, 4);
        tests++;
        if (dut0_pos() !== model_pos() || oc !== 8'd3) begin
            fails++; $display("FAIL rstmid_next_key got pos=%h char=%0d want pos=%h char=3", dut0_pos(), oc, model_pos());
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] oc; logic bs, bp; logic [7:0] c;
        int r, m, l;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 30); m = $urandom_range(0, 30); l = $urandom_range(0, 30);
                do_load(r, m, l);
                tests++;
                if (dut0_pos() !== model_pos()) begin
                    fails++; $display("FAIL rand_load it=%0d got %h want %h", it, dut0_pos(), model_pos());
                end
            end else begin
                c = 8'($urandom);
                do_key(c, lat, oc, bs, bp);
                model_step(21, 4);
                tests++;
                if (dut0_pos() !== model_pos() || oc !== c || lat !== 2) begin
                    fails++; $display("FAIL rand_key it=%0d got pos=%h char=%h lat=%0d want pos=%h char=%h lat=2",
                                      it, dut0_pos(), oc, lat, model_pos(), c);
                end
            end
        end
    endtask

    initial begin
        ifc0.load = 1'b0; ifc0.load_right = '0; ifc0.load_mid = '0; ifc0.load_left = '0;
        ifc0.key_valid = 1'b0; ifc0.key_char = '0;
        ifc1.load = 1'b0; ifc1.load_right = '0; ifc1.load_mid = '0; ifc1.load_left = '0;
        ifc1.key_valid = 1'b0; ifc1.key_char = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_basic_key();
        test_double_step();
        test_wrap();
        test_busy_ignore();
        test_load_sanitize();
        test_load_priority();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
